// File: rtl/dp_pkg.sv
// ============================================================================
// dp_pkg : opcodes, instruction field layout and FSM encoding for the
//          instruction sequencer.   Rev 1.0
// ============================================================================
`default_nettype none

package dp_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LOAD = 4'h1;
    localparam logic [3:0] OP_MOV  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OPC_LSB = 28;
    localparam int OPC_W   = 4;
    localparam int DST_LSB = 25;
    localparam int SRC_LSB = 22;
    localparam int REG_W   = 3;
    localparam int IMM_LSB = 0;
    localparam int IMM_W   = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_HALTED = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

endpackage

`default_nettype wire

// File: rtl/instr_sequencer_if.sv
// ============================================================================
// instr_sequencer_if : control, instruction-memory and datapath signals of the
//                      sequencer.   Rev 1.0
// ============================================================================
`default_nettype none

interface instr_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic [3:0]        opcode;
    logic [2:0]        src_reg;
    logic [2:0]        dest_reg;
    logic [15:0]       immediate;
    logic [15:0]       result;
    logic              issue_valid;
    logic [15:0]       last_result;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        input  start, imem_ack, imem_rdata, result,
        output imem_req, imem_addr, opcode, src_reg, dest_reg, immediate,
               issue_valid, last_result, pc, busy, done, error
    );

    modport slave (
        output start, imem_ack, imem_rdata, result,
        input  imem_req, imem_addr, opcode, src_reg, dest_reg, immediate,
               issue_valid, last_result, pc, busy, done, error
    );
endinterface

`default_nettype wire

// File: rtl/instr_decoder.sv
// ============================================================================
// instr_decoder : splits an instruction word into fields and classifies the
//                 opcode as issuable, halt or illegal.   Rev 1.0
// ============================================================================
`default_nettype none

module instr_decoder
    import dp_pkg::*;
(
    input  wire logic [31:0] instr_i,
    output logic [3:0]       opcode_o,
    output logic [2:0]       dest_o,
    output logic [2:0]       src_o,
    output logic [15:0]      imm_o,
    output logic             issuable_o,
    output logic             halt_o
);
    // Bits [21:16] are reserved and deliberately ignored.
    logic unused_rsvd;
    assign unused_rsvd = ^instr_i[21:16];

    assign opcode_o = instr_i[OPC_LSB +: OPC_W];
    assign dest_o   = instr_i[DST_LSB +: REG_W];
    assign src_o    = instr_i[SRC_LSB +: REG_W];
    assign imm_o    = instr_i[IMM_LSB +: IMM_W];

    always_comb begin
        issuable_o = 1'b0;
        halt_o     = 1'b0;
        case (opcode_o)
            OP_NOP, OP_LOAD, OP_MOV, OP_ADD, OP_XOR: issuable_o = 1'b1;
            OP_HALT:                                 halt_o     = 1'b1;
            default: ;
        endcase
    end
endmodule

`default_nettype wire

// File: rtl/instr_sequencer.sv
// ============================================================================
// instr_sequencer : fetches instructions from imem, issues them one at a time
//                   to the datapath and captures each result.   Rev 1.0
// ============================================================================
`default_nettype none

module instr_sequencer
    import dp_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int ACK_TIMEOUT = 15
)(
    input  wire logic          clk,
    input  wire logic          reset,
    instr_sequencer_if.master  bus
);
    localparam int CNT_W = ($clog2(ACK_TIMEOUT + 1) > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(ACK_TIMEOUT);

    state_t             state_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [CNT_W-1:0]   wait_cnt_q;
    logic               req_q, issue_q, busy_q, done_q, error_q;
    logic [3:0]         opcode_q;
    logic [2:0]         src_q, dest_q;
    logic [15:0]        imm_q, last_q;

    logic [3:0]         dec_opcode;
    logic [2:0]         dec_dest, dec_src;
    logic [15:0]        dec_imm;
    logic               dec_issuable, dec_halt;
    logic [ADDR_W-1:0]  pc_inc_d;

    instr_decoder u_dec (
        .instr_i    (bus.imem_rdata),
        .opcode_o   (dec_opcode),
        .dest_o     (dec_dest),
        .src_o      (dec_src),
        .imm_o      (dec_imm),
        .issuable_o (dec_issuable),
        .halt_o     (dec_halt)
    );

    assign pc_inc_d = pc_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            wait_cnt_q <= '0;
            req_q      <= 1'b0;
            issue_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            opcode_q   <= '0;
            src_q      <= '0;
            dest_q     <= '0;
            imm_q      <= '0;
            last_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_HALTED, S_ERROR: begin
                    if (bus.start) begin
                        state_q    <= S_FETCH;
                        pc_q       <= '0;
                        wait_cnt_q <= '0;
                        req_q      <= 1'b1;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        req_q      <= 1'b0;
                        wait_cnt_q <= '0;
                        if (dec_issuable) begin
                            state_q  <= S_ISSUE;
                            issue_q  <= 1'b1;
                            opcode_q <= dec_opcode;
                            src_q    <= dec_src;
                            dest_q   <= dec_dest;
                            imm_q    <= dec_imm;
                        end else if (dec_halt) begin
                            state_q <= S_HALTED;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_ERROR;
                            busy_q  <= 1'b0;
                            error_q <= 1'b1;
                        end
                    end else if (wait_cnt_q == TIMEOUT_CNT) begin
                        // Counter reaching ACK_TIMEOUT means ACK_TIMEOUT+1 idle cycles.
                        state_q    <= S_ERROR;
                        req_q      <= 1'b0;
                        busy_q     <= 1'b0;
                        error_q    <= 1'b1;
                        wait_cnt_q <= '0;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                S_ISSUE: begin
                    state_q  <= S_WAIT;
                    issue_q  <= 1'b0;
                    opcode_q <= '0;
                    src_q    <= '0;
                    dest_q   <= '0;
                    imm_q    <= '0;
                end
                S_WAIT: begin
                    last_q <= bus.result;
                    if (pc_q == {ADDR_W{1'b1}}) begin
                        state_q <= S_ERROR;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end else begin
                        state_q <= S_FETCH;
                        pc_q    <= pc_inc_d;
                        req_q   <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = pc_q;
    assign bus.pc          = pc_q;
    assign bus.opcode      = opcode_q;
    assign bus.src_reg     = src_q;
    assign bus.dest_reg    = dest_q;
    assign bus.immediate   = imm_q;
    assign bus.issue_valid = issue_q;
    assign bus.last_result = last_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;
endmodule

`default_nettype wire
